// File: rtl/srt_div_r4_param.sv
`default_nettype none
// ============================================================================
// Module   : srt_div_r4_param
// Purpose  : Multi-cycle radix-4 SRT unsigned divider, digit set {-2..+2},
//            on-the-fly quotient conversion and final remainder correction.
// Revision : 1.0  initial release
// ============================================================================
module srt_div_r4_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int PW   = WIDTH + 4;
    localparam int QW   = 2 * ITER;
    localparam int SW   = $clog2(WIDTH);
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_ITER = 3'd2,
        S_CORR = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  num_q, num_d;
    logic [WIDTH-1:0]  den_q, den_d;
    logic [WIDTH-1:0]  dn_q, dn_d;
    logic [SW-1:0]     s_q, s_d;
    logic [PW-1:0]     p_q, p_d;
    logic [QW-1:0]     nlo_q, nlo_d;
    logic [QW-1:0]     q_q, q_d;
    logic [QW-1:0]     qm_q, qm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [SW-1:0]      lz_w;
    logic [2*WIDTH-1:0] nn_w;
    logic [PW-1:0]      wt_w;
    logic [PW-1:0]      dnx_w;
    logic signed [7:0]  est_w;
    logic [2:0]         dsel_w;
    logic signed [7:0]  m2_w, m1_w, m0_w, mn1_w;
    logic [2:0]         dig_w;
    logic [PW-1:0]      pn_w;
    logic [QW-1:0]      qn_w, qmn_w;
    logic [WIDTH-1:0]   rc_w;

    // Highest set bit wins, giving the leading-zero count of the divisor.
    always_comb begin
        lz_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (den_q[i]) lz_w = SW'(WIDTH - 1 - i);
        end
    end

    assign nn_w   = {{WIDTH{1'b0}}, num_q} << lz_w;
    assign wt_w   = (p_q << 2) | PW'(nlo_q[QW-1:QW-2]);
    assign dnx_w  = PW'(dn_q);
    assign est_w  = wt_w[PW-1:PW-8];
    assign dsel_w = dn_q[WIDTH-2:WIDTH-4];

    // Estimate is 4P+bits in units of Dn_msb/8; thresholds stay valid over each
    // divisor interval [8+i, 9+i) in those units, absorbing truncation error.
    always_comb begin
        m2_w = 8'sd12; m1_w = 8'sd3; m0_w = -8'sd5; mn1_w = -8'sd13;
        case (dsel_w)
            3'd0: begin m2_w = 8'sd12; m1_w = 8'sd3; m0_w = -8'sd5;  mn1_w = -8'sd13; end
            3'd1: begin m2_w = 8'sd14; m1_w = 8'sd4; m0_w = -8'sd6;  mn1_w = -8'sd15; end
            3'd2: begin m2_w = 8'sd15; m1_w = 8'sd4; m0_w = -8'sd6;  mn1_w = -8'sd16; end
            3'd3: begin m2_w = 8'sd16; m1_w = 8'sd4; m0_w = -8'sd7;  mn1_w = -8'sd18; end
            3'd4: begin m2_w = 8'sd18; m1_w = 8'sd5; m0_w = -8'sd8;  mn1_w = -8'sd20; end
            3'd5: begin m2_w = 8'sd19; m1_w = 8'sd5; m0_w = -8'sd8;  mn1_w = -8'sd21; end
            3'd6: begin m2_w = 8'sd20; m1_w = 8'sd5; m0_w = -8'sd9;  mn1_w = -8'sd23; end
            default: begin m2_w = 8'sd22; m1_w = 8'sd6; m0_w = -8'sd10; mn1_w = -8'sd25; end
        endcase
    end

    always_comb begin
        if (est_w >= m2_w)       dig_w = 3'b010;
        else if (est_w >= m1_w)  dig_w = 3'b001;
        else if (est_w >= m0_w)  dig_w = 3'b000;
        else if (est_w >= mn1_w) dig_w = 3'b111;
        else                     dig_w = 3'b110;
    end

    always_comb begin
        pn_w  = wt_w;
        qn_w  = q_q << 2;
        qmn_w = (qm_q << 2) | QW'(3);
        case (dig_w)
            3'b010: begin
                pn_w  = wt_w - (dnx_w << 1);
                qn_w  = (q_q << 2) | QW'(2);
                qmn_w = (q_q << 2) | QW'(1);
            end
            3'b001: begin
                pn_w  = wt_w - dnx_w;
                qn_w  = (q_q << 2) | QW'(1);
                qmn_w = q_q << 2;
            end
            3'b111: begin
                pn_w  = wt_w + dnx_w;
                qn_w  = (qm_q << 2) | QW'(3);
                qmn_w = (qm_q << 2) | QW'(2);
            end
            3'b110: begin
                pn_w  = wt_w + (dnx_w << 1);
                qn_w  = (qm_q << 2) | QW'(2);
                qmn_w = (qm_q << 2) | QW'(1);
            end
            default: ;
        endcase
    end

    assign rc_w = p_q[PW-1] ? (p_q[WIDTH-1:0] + dn_q) : p_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        dn_d    = dn_q;
        s_d     = s_q;
        p_d     = p_q;
        nlo_d   = nlo_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d = dividend;
                    den_d = divisor;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend;
                    end else begin
                        state_d = S_NORM;
                        dbz_d   = 1'b0;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_NORM: begin
                s_d     = lz_w;
                dn_d    = den_q << lz_w;
                p_d     = PW'(nn_w[2*WIDTH-1:QW]);
                nlo_d   = nn_w[QW-1:0];
                q_d     = '0;
                qm_d    = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                p_d   = pn_w;
                nlo_d = nlo_q << 2;
                q_d   = qn_w;
                qm_d  = qmn_w;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = S_CORR;
            end
            S_CORR: begin
                quo_d   = p_q[PW-1] ? qm_q[WIDTH-1:0] : q_q[WIDTH-1:0];
                rem_d   = rc_w >> s_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_NORM) || (state_d == S_ITER) || (state_d == S_CORR);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            den_q   <= '0;
            dn_q    <= '0;
            s_q     <= '0;
            p_q     <= '0;
            nlo_q   <= '0;
            q_q     <= '0;
            qm_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            dn_q    <= dn_d;
            s_q     <= s_d;
            p_q     <= p_d;
            nlo_q   <= nlo_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_srt_div_r4_param.sv
`default_nettype none
// Bench for srt_div_r4_param: 8-bit directed scenarios and 16-bit random
// operands checked cycle by cycle against a floor/mod reference model.
module tb_srt_div_r4_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        s8, b8, d8, z8;
    logic [7:0]  n8, dv8, q8, r8;
    logic        s16, b16, d16, z16;
    logic [15:0] n16, dv16, q16, r16;

    srt_div_r4_param #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(s8), .dividend(n8), .divisor(dv8),
        .busy(b8), .done(d8), .quotient(q8), .remainder(r8), .div_by_zero(z8));

    srt_div_r4_param #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(s16), .dividend(n16), .divisor(dv16),
        .busy(b16), .done(d16), .quotient(q16), .remainder(r16), .div_by_zero(z16));

    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              dz;
        int              acc;
        int              due;
    } exp_t;

    exp_t e8q[$];
    exp_t e16q[$];
    int   last_due[2];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Reference: floor/mod, with the divide-by-zero convention; done lands
    // ITER+3 cycles after acceptance (1 cycle for D=0).
    function automatic exp_t model(input int w, input longint unsigned n,
                                   input longint unsigned d, input int acc);
        exp_t e;
        e.acc = acc;
        if (d == 0) begin
            e.q = (64'd1 << w) - 1; e.r = n; e.dz = 1'b1; e.due = acc;
        end else begin
            e.q = n / d; e.r = n % d; e.dz = 1'b0; e.due = acc + (w / 2 + 1) + 2;
        end
        return e;
    endfunction

    // Call at a falling edge; waits until the unit can accept, then drives start.
    task automatic issue(input int k, input longint unsigned n, input longint unsigned d,
                         input bit lit, input longint unsigned lq, input longint unsigned lr);
        exp_t e;
        while (cyc < last_due[k]) @(negedge clk);
        e = model((k == 0) ? 8 : 16, n, d, cyc + 1);
        if (lit) begin e.q = lq; e.r = lr; end
        if (k == 0) begin
            s8 = 1'b1; n8 = n[7:0]; dv8 = d[7:0]; e8q.push_back(e);
        end else begin
            s16 = 1'b1; n16 = n[15:0]; dv16 = d[15:0]; e16q.push_back(e);
        end
        last_due[k] = e.due;
        @(negedge clk);
        if (k == 0) s8 = 1'b0; else s16 = 1'b0;
    endtask

    task automatic mon(input int k, input logic bz, input logic dn, input logic z,
                       input longint unsigned q, input longint unsigned r);
        exp_t e;
        bit   have;
        bit   eb, ed;
        string t;
        have = 1'b0;
        t = (k == 0) ? "w8" : "w16";
        if (k == 0 && e8q.size() > 0)  begin have = 1'b1; e = e8q[0];  end
        if (k == 1 && e16q.size() > 0) begin have = 1'b1; e = e16q[0]; end
        eb = have && (cyc >= e.acc) && (cyc < e.due);
        ed = have && (cyc == e.due);
        chk({t, " busy"}, bz, eb);
        chk({t, " done"}, dn, ed);
        if (ed) begin
            chk({t, " quotient"}, q, e.q);
            chk({t, " remainder"}, r, e.r);
            chk({t, " div_by_zero"}, z, e.dz);
            if (k == 0) void'(e8q.pop_front()); else void'(e16q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        longint p, dn;
        if (!reset) begin
            mon(0, b8, d8, z8, q8, r8);
            mon(1, b16, d16, z16, q16, r16);
            p  = longint'($signed(u8.p_q));
            dn = longint'(u8.dn_q);
            chk("w8 pbound", (3 * p <= 2 * dn) && (3 * p >= -(2 * dn + 3)), 1);
            p  = longint'($signed(u16.p_q));
            dn = longint'(u16.dn_q);
            chk("w16 pbound", (3 * p <= 2 * dn) && (3 * p >= -(2 * dn + 3)), 1);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    longint unsigned cn[16] = '{64'hFFFF, 64'h1234, 64'hFFFF, 64'hFFFE, 64'hFFFF, 64'h8000,
                                64'h7FFF, 64'd1234, 64'd0,    64'd5,    64'hFFFF, 64'hFFFF,
                                64'd1,    64'h4000, 64'hABCD, 64'd65535};
    longint unsigned cd[16] = '{64'd1,    64'd1,    64'hFFFF, 64'hFFFF, 64'h8000, 64'h8000,
                                64'h8000, 64'd0,    64'h1111, 64'd9,    64'd2,    64'd3,
                                64'd1,    64'd4,    64'h0100, 64'd255};

    initial begin
        int a;
        longint unsigned n, d;
        reset = 1'b1; s8 = 1'b0; s16 = 1'b0;
        n8 = '0; dv8 = '0; n16 = '0; dv16 = '0;
        last_due[0] = -1; last_due[1] = -1;
        repeat (3) @(negedge clk);
        chk("reset busy", b8, 0);
        chk("reset done", d8, 0);
        chk("reset quotient", q8, 0);
        chk("reset remainder", r8, 0);
        chk("reset div_by_zero", z16, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 200, 7, 1, 28, 4);
        issue(0, 255, 1, 1, 255, 0);
        issue(0, 5, 9, 1, 0, 5);
        issue(0, 0, 3, 1, 0, 0);
        issue(0, 77, 0, 1, 8'hFF, 77);

        // start mid-ITER is dropped; start during DONE is taken
        issue(0, 100, 10, 1, 10, 0);
        a = last_due[0] - 7;
        while (cyc < a + 2) @(negedge clk);
        s8 = 1'b1; n8 = 8'd9; dv8 = 8'd3;
        @(negedge clk);
        s8 = 1'b0;
        issue(0, 9, 3, 1, 3, 0);

        // asynchronous reset in the third ITER cycle abandons the division
        issue(0, 123, 5, 1, 24, 3);
        a = last_due[0] - 7;
        while (cyc < a + 3) @(negedge clk);
        #1 reset = 1'b1;
        e8q.delete();
        last_due[0] = -1;
        #1;
        chk("async rst busy", b8, 0);
        chk("async rst done", d8, 0);
        chk("async rst quotient", q8, 0);
        chk("async rst remainder", r8, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(0, 50, 6, 1, 8, 2);

        issue(1, 1000, 7, 1, 142, 6);
        issue(1, 16'hFFFF, 16'h00FF, 1, 257, 0);
        for (int i = 0; i < 16; i++) issue(1, cn[i], cd[i], 0, 0, 0);
        for (int i = 0; i < 16; i++) issue(1, longint'($urandom_range(0, 65535)), 64'd1 << i, 0, 0, 0);
        for (int i = 0; i < 5000; i++) begin
            n = longint'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: d = longint'($urandom_range(0, 65535));
                1: d = longint'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
                2: d = 64'd1 << $urandom_range(0, 15);
                default: begin
                    d = longint'($urandom_range(1, 65535));
                    n = n % d;
                end
            endcase
            issue(1, n, d, 0, 0, 0);
        end

        while (cyc <= last_due[0] || cyc <= last_due[1]) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("w8 pending", e8q.size(), 0);
        chk("w16 pending", e16q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
